down_counter_tc: RTL
====================

Name: down_counter_tc

Overview:
- Loadable down-counter with terminal-count pulse: the decrement-side counterpart of the team's INR/CLR up-counter.
- The host loads a start value and issues DEC strobes. The block counts down to zero, then pulses TC for one cycle.
- Used as an event budget or timeout alongside the up-counter. Also flags DEC strobes that arrive when no count is loaded.

Parameters:
- WIDTH, 4, bit width of the count and the load value.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- CLR  input  1  asynchronous, active-high reset.
- LD  input  1  load strobe; samples DIN.
- DIN  input  WIDTH  load value.
- DEC  input  1  decrement strobe; acts once per clock edge while high.
- count  output  WIDTH  current count (registered).
- BUSY  output  1  high while in state RUN.
- ZERO  output  1  combinational: count == 0.
- TC  output  1  terminal-count pulse: one cycle, registered.
- UFL  output  1  sticky underflow flag.

Behaviour:
- Reset (CLR=1, asynchronous, takes effect immediately): count=0, state=IDLE, BUSY=0, TC=0, UFL=0. Holds while CLR is high.
- Reset mid-count aborts the count: no TC, value lost.
- States: IDLE, RUN, DONE. BUSY = (state==RUN).
- Input priority at each edge: CLR > LD > DEC.
- LD, any state:
  - count<=DIN, UFL<=0, TC<=0.
  - next state = RUN if DIN!=0, else IDLE (loading 0 never produces TC).
  - A DEC in the same cycle is ignored.
- RUN, DEC=1, count>1: count<=count-1; stay in RUN.
- RUN, DEC=1, count==1: count<=0, TC<=1 at the same edge, state<=DONE.
  - Latency: TC is high in the first cycle after the edge that samples the final DEC.
- RUN, DEC=0: hold.
- DONE: lasts exactly one cycle, then IDLE. TC<=0 on leaving DONE.
  - DEC in DONE is treated as in IDLE (see underflow rule).
- IDLE, DEC=1, no LD: count unchanged (stays 0, no wrap to all-ones), UFL<=1.
- UFL is cleared only by LD or CLR.
- Wrap-around: never. Count saturates at 0.
- Maximum load value is 2^WIDTH-1. With DEC held high it gives exactly DIN cycles of BUSY before TC.
- LD during RUN restarts the count from the new DIN; no TC for the abandoned count.
- LD in the DONE cycle: the load wins, TC drops next cycle, and the state follows the LD rule.

Optional Feature:
- Macro: DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined:
  - Adds a WIDTH-bit reload register, written on each LD with DIN.
  - In RUN with DEC=1 and count==1: count<=reload value, TC<=1, state stays RUN. TC is still exactly one cycle.
  - DONE is unreachable; BUSY stays high until LD with 0 or CLR.
  - If the reload value is 0, the block behaves as when the macro is not defined.
- Not defined: no reload register; behaviour exactly as in Behaviour.

Test Plan:
- CLR pulsed high mid-cycle, not on a clock edge -> count=0, BUSY=0, TC=0, UFL=0 immediately.
- LD with DIN=3, then DEC held high 3 cycles -> count 3,2,1,0; TC high for 1 cycle only in the cycle after the 3rd DEC edge; BUSY low from that cycle on; ZERO=1.
- LD DIN=5, 2 DECs, then LD DIN=2 with DEC high in the same cycle -> count=2 (DEC ignored); 2 further DECs -> TC once; no TC for the abandoned count.
- From IDLE with count=0, DEC for 2 cycles -> count stays 0 (no wrap to 15), UFL=1 and sticky; LD DIN=4 -> UFL=0.
- LD DIN=0 -> count=0, BUSY=0, TC never asserted.
- DOWN_COUNTER_AUTO_RELOAD_EN defined, LD DIN=2, DEC held high 6 cycles -> TC pulses after DEC edges 2, 4 and 6; count sequence 2,1,2,1,2,1,2; BUSY stays 1.

Source files
------------

// File: rtl/down_counter_tc.sv
// Loadable down-counter with a one-cycle terminal-count pulse and a sticky underflow flag.
// Optional DOWN_COUNTER_AUTO_RELOAD_EN restarts the count from the last loaded value at terminal count.
module down_counter_tc #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             LD,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DEC,
    output logic [WIDTH-1:0] count,
    output logic             BUSY,
    output logic             ZERO,
    output logic             TC,
    output logic             UFL
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic             ufl_r;
    logic [WIDTH-1:0] reload_s;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_r;

    // Reload value tracks every load so the period follows the most recent DIN.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            reload_r <= CNT_ZERO;
        end else if (LD) begin
            reload_r <= DIN;
        end else begin
            reload_r <= reload_r;
        end
    end

    assign reload_s = reload_r;
`else
    assign reload_s = CNT_ZERO;
`endif

    // Control FSM: load has priority over decrement; a zero reload value means one-shot operation.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state_r <= IDLE;
            count_r <= CNT_ZERO;
            tc_r    <= 1'b0;
            ufl_r   <= 1'b0;
        end else if (LD) begin
            count_r <= DIN;
            ufl_r   <= 1'b0;
            tc_r    <= 1'b0;
            state_r <= (DIN != CNT_ZERO) ? RUN : IDLE;
        end else begin
            case (state_r)
                RUN: begin
                    ufl_r <= ufl_r;
                    if (DEC) begin
                        if (count_r > CNT_ONE) begin
                            count_r <= count_r - CNT_ONE;
                            tc_r    <= 1'b0;
                            state_r <= RUN;
                        end else if (reload_s != CNT_ZERO) begin
                            count_r <= reload_s;
                            tc_r    <= 1'b1;
                            state_r <= RUN;
                        end else begin
                            count_r <= CNT_ZERO;
                            tc_r    <= 1'b1;
                            state_r <= DONE;
                        end
                    end else begin
                        count_r <= count_r;
                        tc_r    <= 1'b0;
                        state_r <= RUN;
                    end
                end
                // DONE behaves like IDLE for a stray DEC; the count never wraps below zero.
                IDLE, DONE: begin
                    count_r <= count_r;
                    tc_r    <= 1'b0;
                    state_r <= IDLE;
                    if (DEC) begin
                        ufl_r <= 1'b1;
                    end else begin
                        ufl_r <= ufl_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    count_r <= CNT_ZERO;
                    tc_r    <= 1'b0;
                    ufl_r   <= ufl_r;
                end
            endcase
        end
    end

    assign count = count_r;
    assign BUSY  = (state_r == RUN);
    assign ZERO  = (count_r == CNT_ZERO);
    assign TC    = tc_r;
    assign UFL   = ufl_r;

endmodule
